// File: rtl/fetch_sequencer.sv
// Instruction fetch / program-counter stage: fetches over a req/ack handshake,
// issues the opcode for one cycle, resolves branches and freezes on HALT.
module fetch_sequencer #(
  parameter int PC_W     = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [1:0]         jump,
  input  logic               zero,
  input  logic               gt,
  output logic [3:0]         opcd,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [15:0]        retired
);

  // state   | meaning
  // FETCH   | request imem[pc], wait for ack, capture IR
  // ISSUE   | present IR opcode to the control unit for one cycle
  // RESOLVE | opcode back to NOP, evaluate jump/flags, retire
  // HALT    | frozen until reset
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_ISSUE   = 2'd1,
    S_RESOLVE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] RESET_PC_V = RESET_PC[PC_W-1:0];
  localparam logic [3:0]      OP_HALT    = 4'b1111;

  state_t           state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [3:0]       ir_op;
  logic [PC_W-1:0]  target;
  logic             take;

  assign ir_op  = ir[INSTR_W-1 -: 4];
  assign target = ir[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   if (imem_ack) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_RESOLVE;
      S_RESOLVE: state_nxt = (ir_op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    opcd     = 4'b0000;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_ISSUE: opcd     = ir_op;
      default: ;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (jump)
      2'b11:   take = 1'b1;
      2'b01:   take = zero;
      2'b10:   take = gt;
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC_V;
      ir      <= '0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) ir <= imem_data;
      if (state == S_RESOLVE) begin
        retired <= retired + 16'd1;
        // a retiring HALT keeps pc pointing at itself
        if (ir_op == OP_HALT) halted <= 1'b1;
        else                  pc     <= take ? target : pc + 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign instr     = ir;

endmodule
